// File: rtl/xif_aes_offload_issuer_pkg.sv
// Shared types for the XIF AES32 offload issuer: scoreboard entry and issue FSM states.
package xif_aes_offload_issuer_pkg;

  typedef struct packed {
    logic       valid;
    logic       kill;
    logic [4:0] rd;
  } xif_sb_entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    COMMIT = 2'd2
  } issuer_state_e;

endpackage

// File: rtl/xif_id_scoreboard.sv
// ID-indexed table of committed-but-unretired XIF instructions with an occupancy count.
module xif_id_scoreboard
  import xif_aes_offload_issuer_pkg::*;
#(
  parameter int ID_W = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            alloc_i,
  input  logic [ID_W-1:0] alloc_id_i,
  input  logic [4:0]      alloc_rd_i,
  input  logic            alloc_kill_i,
  input  logic            free_a_i,
  input  logic [ID_W-1:0] free_a_id_i,
  input  logic            free_b_i,
  input  logic [ID_W-1:0] free_b_id_i,
  input  logic [ID_W-1:0] look_a_id_i,
  output logic            look_a_valid_o,
  input  logic [ID_W-1:0] look_b_id_i,
  output logic            look_b_valid_o,
  output logic            look_b_kill_o,
  output logic [ID_W:0]   count_o
);

  localparam int NUM_IDS = 2 ** ID_W;
  localparam int CW      = ID_W + 1;

  xif_sb_entry_t   ent_q [NUM_IDS];
  logic [ID_W:0]   count_q;

  // Frees are only requested for valid entries, so the count tracks the valid bits exactly.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_IDS; i++) ent_q[i] <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_IDS; i++) begin
        if (alloc_i && alloc_id_i == ID_W'(i))
          ent_q[i] <= '{valid: 1'b1, kill: alloc_kill_i, rd: alloc_rd_i};
        else if ((free_a_i && free_a_id_i == ID_W'(i)) ||
                 (free_b_i && free_b_id_i == ID_W'(i)))
          ent_q[i].valid <= 1'b0;
      end
      count_q <= count_q + CW'(alloc_i) - CW'(free_a_i) - CW'(free_b_i);
    end
  end

  assign look_a_valid_o = ent_q[look_a_id_i].valid;
  assign look_b_valid_o = ent_q[look_b_id_i].valid;
  assign look_b_kill_o  = ent_q[look_b_id_i].kill;
  assign count_o        = count_q;

endmodule

// File: rtl/xif_aes_offload_issuer.sv
// Core-side XIF initiator for AES32 offload: issue, commit, result scoreboarding and writeback.
module xif_aes_offload_issuer
  import xif_aes_offload_issuer_pkg::*;
#(
  parameter int X_ID_WIDTH      = 4,
  parameter int X_RFR_WIDTH     = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [31:0]            req_instr_i,
  input  logic [X_RFR_WIDTH-1:0] req_rs1_i,
  input  logic [X_RFR_WIDTH-1:0] req_rs2_i,
  input  logic                   req_kill_i,
  output logic                   issue_valid_o,
  input  logic                   issue_ready_i,
  output logic [31:0]            issue_instr_o,
  output logic [X_RFR_WIDTH-1:0] issue_rs0_o,
  output logic [X_RFR_WIDTH-1:0] issue_rs1_o,
  output logic [1:0]             issue_rs_valid_o,
  output logic [X_ID_WIDTH-1:0]  issue_id_o,
  input  logic                   issue_accept_i,
  output logic                   commit_valid_o,
  output logic [X_ID_WIDTH-1:0]  commit_id_o,
  output logic                   commit_kill_o,
  input  logic                   result_valid_i,
  output logic                   result_ready_o,
  input  logic [X_ID_WIDTH-1:0]  result_id_i,
  input  logic [4:0]             result_rd_i,
  input  logic [X_RFR_WIDTH-1:0] result_data_i,
  input  logic                   result_we_i,
  output logic                   wb_valid_o,
  input  logic                   wb_ready_i,
  output logic [4:0]             wb_rd_o,
  output logic [X_RFR_WIDTH-1:0] wb_data_o,
  output logic                   reject_o,
  output logic                   err_o
);

  localparam int CW = X_ID_WIDTH + 1;

  issuer_state_e          state_q, state_d;
  logic [X_ID_WIDTH-1:0]  id_q;
  logic [31:0]            instr_q;
  logic [X_RFR_WIDTH-1:0] rs1_q, rs2_q;
  logic                   kill_q;

  logic                   alloc, kill_free, res_hs, res_hit, res_free;
  logic                   next_busy, look_kill, look_valid;
  logic [X_ID_WIDTH:0]    sb_count;

  // Request is captured on entry to ISSUE so the XIF payload stays stable until handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      id_q    <= '0;
      instr_q <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == ISSUE) begin
        instr_q <= req_instr_i;
        rs1_q   <= req_rs1_i;
        rs2_q   <= req_rs2_i;
        kill_q  <= req_kill_i;
      end
      if (state_q == COMMIT) id_q <= id_q + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    reject_o    = 1'b0;
    alloc       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i && sb_count < CW'(MAX_OUTSTANDING) && !next_busy)
          state_d = ISSUE;
      end
      ISSUE: begin
        if (issue_ready_i) begin
          req_ready_o = 1'b1;
          if (issue_accept_i) begin
            alloc   = 1'b1;
            state_d = COMMIT;
          end else begin
            reject_o = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign issue_valid_o    = (state_q == ISSUE);
  assign issue_instr_o    = instr_q;
  assign issue_rs0_o      = rs1_q;
  assign issue_rs1_o      = rs2_q;
  assign issue_rs_valid_o = issue_valid_o ? 2'b11 : 2'b00;
  assign issue_id_o       = id_q;
  assign commit_valid_o   = (state_q == COMMIT);
  assign commit_id_o      = id_q;
  assign commit_kill_o    = kill_q;

  // A killed instruction never produces a result, so its slot is released at commit.
  assign kill_free      = commit_valid_o && kill_q;
  assign result_ready_o = !wb_valid_o || wb_ready_i;
  assign res_hs         = result_valid_i && result_ready_o;
  assign res_hit        = look_valid && !look_kill;
  assign res_free       = res_hs && res_hit;

  xif_id_scoreboard #(.ID_W(X_ID_WIDTH)) u_sb (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .alloc_i        (alloc),
    .alloc_id_i     (id_q),
    .alloc_rd_i     (instr_q[11:7]),
    .alloc_kill_i   (kill_q),
    .free_a_i       (kill_free),
    .free_a_id_i    (id_q),
    .free_b_i       (res_free),
    .free_b_id_i    (result_id_i),
    .look_a_id_i    (id_q),
    .look_a_valid_o (next_busy),
    .look_b_id_i    (result_id_i),
    .look_b_valid_o (look_valid),
    .look_b_kill_o  (look_kill),
    .count_o        (sb_count)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_valid_o <= 1'b0;
      wb_rd_o    <= '0;
      wb_data_o  <= '0;
      err_o      <= 1'b0;
    end else begin
      if (res_free && result_we_i) begin
        wb_valid_o <= 1'b1;
        wb_rd_o    <= result_rd_i;
        wb_data_o  <= result_data_i;
      end else if (wb_ready_i) begin
        wb_valid_o <= 1'b0;
      end
      if (res_hs && !res_hit) err_o <= 1'b1;
    end
  end

endmodule
